// File: rtl/axi4_mem_responder_if.sv
// AXI4 slave-side bus bundle for axi4_mem_responder.
// Default AXI4_* widths apply when the build does not provide them.
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_STRB_WIDTH
`define AXI4_STRB_WIDTH (`AXI4_DATA_WIDTH / 8)
`endif
`ifndef AXI4_LEN_WIDTH
`define AXI4_LEN_WIDTH 8
`endif
`ifndef AXI4_SIZE_WIDTH
`define AXI4_SIZE_WIDTH 3
`endif
`ifndef AXI4_BURST_WIDTH
`define AXI4_BURST_WIDTH 2
`endif
`ifndef AXI4_RESP_WIDTH
`define AXI4_RESP_WIDTH 2
`endif

interface axi4_mem_responder_if;
  localparam int unsigned ID_W    = `AXI4_ID_WIDTH;
  localparam int unsigned ADDR_W  = `AXI4_ADDR_WIDTH;
  localparam int unsigned DATA_W  = `AXI4_DATA_WIDTH;
  localparam int unsigned STRB_W  = `AXI4_STRB_WIDTH;
  localparam int unsigned LEN_W   = `AXI4_LEN_WIDTH;
  localparam int unsigned SIZE_W  = `AXI4_SIZE_WIDTH;
  localparam int unsigned BURST_W = `AXI4_BURST_WIDTH;
  localparam int unsigned RESP_W  = `AXI4_RESP_WIDTH;

  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awvalid;
  logic               awready;
  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;
  logic [ID_W-1:0]    bid;
  logic [RESP_W-1:0]  bresp;
  logic               bvalid;
  logic               bready;
  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arvalid;
  logic               arready;
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a dual-port RAM with independent read and write FSMs.
// Define AXI4_MEM_RESPONDER_BSTALL_EN to hold each write response for 16 cycles.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif

module axi4_mem_responder #(
  parameter int unsigned                 MEM_DEPTH_LOG2 = 10,
  parameter logic [`AXI4_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4_mem_responder_if.slave  s_axi
);
  localparam int unsigned ID_W       = s_axi.ID_W;
  localparam int unsigned ADDR_W     = s_axi.ADDR_W;
  localparam int unsigned DATA_W     = s_axi.DATA_W;
  localparam int unsigned STRB_W     = s_axi.STRB_W;
  localparam int unsigned LEN_W      = s_axi.LEN_W;
  localparam int unsigned SIZE_W     = s_axi.SIZE_W;
  localparam int unsigned BURST_W    = s_axi.BURST_W;
  localparam int unsigned RESP_W     = s_axi.RESP_W;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
  localparam int unsigned WIN_LOG2   = MEM_DEPTH_LOG2 + BYTE_SHIFT;
  localparam int unsigned DEPTH      = 2 ** MEM_DEPTH_LOG2;

  localparam logic [BURST_W-1:0] BURST_FIXED = BURST_W'(0);
  localparam logic [BURST_W-1:0] BURST_WRAP  = BURST_W'(2);
  localparam logic [RESP_W-1:0]  RESP_OKAY   = RESP_W'(0);
  localparam logic [RESP_W-1:0]  RESP_SLVERR = RESP_W'(2);
  localparam logic [RESP_W-1:0]  RESP_DECERR = RESP_W'(3);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Out-of-window takes priority over an unsupported WRAP burst.
  function automatic logic [RESP_W-1:0] burst_resp(input logic [ADDR_W-1:0]  addr,
                                                   input logic [BURST_W-1:0] burst);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    if ((off >> WIN_LOG2) != '0) return RESP_DECERR;
    if (burst == BURST_WRAP)     return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return MEM_DEPTH_LOG2'((addr - BASE_ADDR) >> BYTE_SHIFT);
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0]  addr,
                                                  input logic [SIZE_W-1:0]  size,
                                                  input logic [BURST_W-1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + (ADDR_W'(1) << size);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_e           w_state_q, w_state_d;
  logic [ID_W-1:0]    w_id_q, w_id_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
  logic [LEN_W-1:0]   w_len_q, w_len_d;
  logic [SIZE_W-1:0]  w_size_q, w_size_d;
  logic [BURST_W-1:0] w_burst_q, w_burst_d;
  logic [RESP_W-1:0]  w_resp_q, w_resp_d;
  logic [LEN_W-1:0]   w_beat_q, w_beat_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
  localparam int unsigned STALL_W = 4;
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  r_state_e           r_state_q, r_state_d;
  logic [ID_W-1:0]    r_id_q, r_id_d;
  logic [ADDR_W-1:0]  r_addr_q, r_addr_d;
  logic [LEN_W-1:0]   r_len_q, r_len_d;
  logic [SIZE_W-1:0]  r_size_q, r_size_d;
  logic [BURST_W-1:0] r_burst_q, r_burst_d;
  logic [RESP_W-1:0]  r_resp_q, r_resp_d;
  logic [LEN_W-1:0]   r_beat_q, r_beat_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic               rlast_q, rlast_d;
  logic [DATA_W-1:0]  rdata_q;

  logic                      ram_we_c;
  logic                      ram_re_c;
  logic                      w_last_beat_c;
  logic [MEM_DEPTH_LOG2-1:0] w_idx_c;
  logic [MEM_DEPTH_LOG2-1:0] r_idx_c;

  assign w_last_beat_c = (w_beat_q == w_len_q);
  assign w_idx_c       = word_idx(w_addr_q);
  assign r_idx_c       = word_idx(r_addr_q);

  // Write channel next-state
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_resp_d  = w_resp_q;
    w_beat_d  = w_beat_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    ram_we_c  = 1'b0;
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
    stall_d   = stall_q;
`endif
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          w_id_d    = s_axi.awid;
          w_addr_d  = s_axi.awaddr;
          w_len_d   = s_axi.awlen;
          w_size_d  = s_axi.awsize;
          w_burst_d = s_axi.awburst;
          w_resp_d  = burst_resp(s_axi.awaddr, s_axi.awburst);
          w_beat_d  = '0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          ram_we_c = (w_resp_q == RESP_OKAY);
          w_addr_d = step_addr(w_addr_q, w_size_q, w_burst_q);
          w_beat_d = w_beat_q + LEN_W'(1);
          // Burst ends on wlast or on the awlen-th beat, whichever comes first.
          if (s_axi.wlast || w_last_beat_c) begin
            if ((s_axi.wlast != w_last_beat_c) && (w_resp_q != RESP_DECERR)) begin
              w_resp_d = RESP_SLVERR;
            end
            wready_d  = 1'b0;
            w_state_d = W_RESP;
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
            stall_d   = '0;
`else
            bvalid_d  = 1'b1;
`endif
          end
        end
      end
      W_RESP: begin
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
        if (!bvalid_q) begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_q == {STALL_W{1'b1}}) bvalid_d = 1'b1;
        end
`endif
        if (bvalid_q && s_axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read channel next-state
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_resp_d  = r_resp_q;
    r_beat_d  = r_beat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    ram_re_c  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          r_id_d    = s_axi.arid;
          r_addr_d  = s_axi.araddr;
          r_len_d   = s_axi.arlen;
          r_size_d  = s_axi.arsize;
          r_burst_d = s_axi.arburst;
          r_resp_d  = burst_resp(s_axi.araddr, s_axi.arburst);
          r_beat_d  = '0;
          arready_d = 1'b0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re_c  = 1'b1;
        rvalid_d  = 1'b1;
        rlast_d   = (r_beat_q == r_len_q);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid_q && s_axi.rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = step_addr(r_addr_q, r_size_q, r_burst_q);
            r_beat_d  = r_beat_q + LEN_W'(1);
            r_state_d = R_FETCH;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_resp_q  <= '0;
      w_beat_q  <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
      stall_q   <= '0;
`endif
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_resp_q  <= '0;
      r_beat_q  <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_resp_q  <= w_resp_d;
      w_beat_q  <= w_beat_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
      stall_q   <= stall_d;
`endif
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_resp_q  <= r_resp_d;
      r_beat_q  <= r_beat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_c][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // RAM read port: read-first against a same-cycle write, zero data on error bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ram_re_c) begin
      rdata_q <= (r_resp_q == RESP_OKAY) ? mem[r_idx_c] : '0;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bid     = w_id_q;
  assign s_axi.bresp   = w_resp_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rid     = r_id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = r_resp_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rvalid  = rvalid_q;
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: expected R beats are queued when a read is
// issued and popped as the DUT returns them; write responses are checked per scenario.
module tb_axi4_mem_responder;
  localparam int unsigned DW = 512;
  localparam int unsigned SW = 64;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_mem_responder_if s_axi ();

  axi4_mem_responder #(.MEM_DEPTH_LOG2(10), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (s_axi)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_data [$];
  logic [6:0]    exp_attr [$];
  logic [DW-1:0] wq_data  [$];
  logic [SW-1:0] wq_strb  [$];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 6) & 32'h3FF);
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] w;
    w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : '0;
    for (int b = 0; b < SW; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model_mem[widx(a)] = w;
  endfunction

  // attr = {id[3:0], resp[1:0], last}
  function automatic void push_exp(input logic [DW-1:0] d, input logic [1:0] resp, input logic last,
                                   input logic [3:0] id);
    exp_data.push_back(d);
    exp_attr.push_back({id, resp, last});
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int last_idx,
                          output logic [1:0] bresp, output logic [3:0] bid, output int lat);
    int cyc;
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len;
    s_axi.awsize = 3'd6; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
    cyc = 0;
    while (!s_axi.awready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 100) begin n_checks++; $display("FAIL aw_timeout: got no awready, expected awready"); end
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
    for (int i = 0; i <= last_idx; i++) begin
      s_axi.wdata = wq_data[i]; s_axi.wstrb = wq_strb[i];
      s_axi.wlast = (i == last_idx); s_axi.wvalid = 1'b1;
      cyc = 0;
      while (!s_axi.wready && cyc < 100) begin @(posedge clk); #1; cyc++; end
      if (cyc >= 100) begin n_checks++; $display("FAIL w_timeout: got no wready, expected wready"); end
      @(posedge clk); #1;
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    wq_data.delete(); wq_strb.delete();
    s_axi.bready = 1'b1;
    lat = 0;
    while (!s_axi.bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
    bresp = s_axi.bvalid ? s_axi.bresp : 2'bxx;
    bid   = s_axi.bvalid ? s_axi.bid   : 4'bxxxx;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
  endtask

  // Issues an AR and pops/compares the scoreboard on every R handshake.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle, input string name);
    int cyc, beats;
    bit done, held;
    logic [DW-1:0] hd, ed;
    logic [6:0] ha, ea, oa;
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
    s_axi.arsize = 3'd6; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
    cyc = 0;
    while (!s_axi.arready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (cyc >= 100) begin n_checks++; $display("FAIL %s ar_timeout: got no arready, expected arready", name); end
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    beats = 0; done = 0; held = 0; cyc = 0;
    while (!done && cyc < 2000) begin
      s_axi.rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (s_axi.rvalid) begin
        oa = {s_axi.rid, s_axi.rresp, s_axi.rlast};
        if (held) begin
          n_checks++;
          if ({oa, s_axi.rdata} !== {ha, hd})
            $display("FAIL %s stall_hold: got attr %h data %h, expected attr %h data %h", name, oa, s_axi.rdata, ha, hd);
          else n_pass++;
        end
        if (s_axi.rready) begin
          held = 0;
          if (exp_data.size() == 0) begin
            n_checks++;
            $display("FAIL %s extra_beat: got beat %0d, expected no beat", name, beats);
            done = 1;
          end else begin
            ed = exp_data.pop_front(); ea = exp_attr.pop_front();
            n_checks++;
            if (s_axi.rdata !== ed) $display("FAIL %s rdata beat %0d: got %h, expected %h", name, beats, s_axi.rdata, ed);
            else n_pass++;
            n_checks++;
            if (oa !== ea) $display("FAIL %s id_resp_last beat %0d: got %b, expected %b", name, beats, oa, ea);
            else n_pass++;
            done = s_axi.rlast;
          end
          beats++;
        end else begin
          held = 1; hd = s_axi.rdata; ha = oa;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_axi.rready = 1'b0;
    n_checks++;
    if (!done || exp_data.size() != 0)
      $display("FAIL %s beat_count: got %0d beats (done=%0d), expected %0d", name, beats, done, beats + exp_data.size());
    else n_pass++;
    exp_data.delete(); exp_attr.delete();
  endtask

  task automatic test_reset();
    logic [1:0] br; logic [3:0] bi; int lat;
    n_checks++; if (s_axi.awready !== 1'b1) $display("FAIL rst_awready: got %b, expected 1", s_axi.awready); else n_pass++;
    n_checks++; if (s_axi.arready !== 1'b1) $display("FAIL rst_arready: got %b, expected 1", s_axi.arready); else n_pass++;
    n_checks++; if (s_axi.wready !== 1'b0) $display("FAIL rst_wready: got %b, expected 0", s_axi.wready); else n_pass++;
    n_checks++; if (s_axi.bvalid !== 1'b0) $display("FAIL rst_bvalid: got %b, expected 0", s_axi.bvalid); else n_pass++;
    n_checks++; if (s_axi.rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b, expected 0", s_axi.rvalid); else n_pass++;
    n_checks++;
    if ({s_axi.rlast, s_axi.rresp, s_axi.rid, s_axi.bresp, s_axi.bid} !== '0 || s_axi.rdata !== '0)
      $display("FAIL rst_payload: got rlast %b rresp %b rid %h bresp %b bid %h, expected all 0",
               s_axi.rlast, s_axi.rresp, s_axi.rid, s_axi.bresp, s_axi.bid);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    // Preload words 0..7 so every later read has defined model data.
    for (int i = 0; i < 8; i++) begin wq_data.push_back(rand_word()); wq_strb.push_back('1); end
    for (int i = 0; i < 8; i++) m_write(32'(i * 64), wq_data[i], '1);
    do_write(4'd0, 32'h0, 8'd7, INCR, 7, br, bi, lat);
    n_checks++; if (br !== 2'b00) $display("FAIL preload_bresp: got %b, expected 00", br); else n_pass++;
  endtask

  task automatic test_single_write();
    logic [1:0] br; logic [3:0] bi; int lat; logic [DW-1:0] d;
    d = {(DW/8){8'hA5}};
    wq_data.push_back(d); wq_strb.push_back('1);
    do_write(4'd5, 32'h40, 8'd0, INCR, 0, br, bi, lat);
    m_write(32'h40, d, '1);
    n_checks++; if (br !== 2'b00) $display("FAIL single_bresp: got %b, expected 00", br); else n_pass++;
    n_checks++; if (bi !== 4'd5) $display("FAIL single_bid: got %h, expected 5", bi); else n_pass++;
    push_exp(model_mem[widx(32'h40)], 2'b00, 1'b1, 4'd6);
    do_read(4'd6, 32'h40, 8'd0, INCR, 1'b0, "single_read");
  endtask

  task automatic test_partial_strobe();
    logic [1:0] br; logic [3:0] bi; int lat; logic [DW-1:0] d;
    d = rand_word();
    wq_data.push_back(d); wq_strb.push_back(64'h0F);
    do_write(4'd1, 32'h40, 8'd0, INCR, 0, br, bi, lat);
    m_write(32'h40, d, 64'h0F);
    n_checks++; if (br !== 2'b00) $display("FAIL strobe_bresp: got %b, expected 00", br); else n_pass++;
    push_exp(model_mem[widx(32'h40)], 2'b00, 1'b1, 4'd2);
    do_read(4'd2, 32'h40, 8'd0, INCR, 1'b0, "strobe_read");
  endtask

  task automatic test_incr_burst();
    logic [1:0] br; logic [3:0] bi; int lat;
    for (int i = 0; i < 4; i++) begin wq_data.push_back(rand_word()); wq_strb.push_back('1); end
    for (int i = 0; i < 4; i++) m_write(32'(i * 64), wq_data[i], '1);
    do_write(4'd3, 32'h0, 8'd3, INCR, 3, br, bi, lat);
    n_checks++; if (br !== 2'b00 || bi !== 4'd3) $display("FAIL incr_b: got resp %b id %h, expected 00 3", br, bi); else n_pass++;
    for (int i = 0; i < 4; i++) push_exp(model_mem[i], 2'b00, i == 3, 4'd4);
    do_read(4'd4, 32'h0, 8'd3, INCR, 1'b1, "incr_read");
  endtask

  task automatic test_fixed_burst();
    logic [1:0] br; logic [3:0] bi; int lat;
    wq_data.push_back(rand_word()); wq_strb.push_back('1);
    wq_data.push_back(rand_word()); wq_strb.push_back(64'hFF00);
    wq_data.push_back(rand_word()); wq_strb.push_back(64'hF000_0000_0000_0000);
    for (int i = 0; i < 3; i++) m_write(32'h200, wq_data[i], wq_strb[i]);
    do_write(4'd8, 32'h200, 8'd2, FIXED, 2, br, bi, lat);
    n_checks++; if (br !== 2'b00) $display("FAIL fixed_bresp: got %b, expected 00", br); else n_pass++;
    push_exp(model_mem[widx(32'h200)], 2'b00, 1'b0, 4'd9);
    push_exp(model_mem[widx(32'h200)], 2'b00, 1'b1, 4'd9);
    do_read(4'd9, 32'h200, 8'd1, FIXED, 1'b0, "fixed_read");
  endtask

  task automatic test_reset_mid_burst();
    int hs, cyc;
    s_axi.arid = 4'd7; s_axi.araddr = 32'h0; s_axi.arlen = 8'd3;
    s_axi.arsize = 3'd6; s_axi.arburst = INCR; s_axi.arvalid = 1'b1;
    cyc = 0;
    while (!s_axi.arready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 100) begin
      if (s_axi.rvalid) begin
        n_checks++;
        if (s_axi.rdata !== model_mem[hs]) $display("FAIL midrst_beat%0d: got %h, expected %h", hs, s_axi.rdata, model_mem[hs]);
        else n_pass++;
        hs++;
      end
      @(posedge clk); #1; cyc++;
    end
    s_axi.rready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (s_axi.rvalid !== 1'b0) $display("FAIL midrst_rvalid: got %b, expected 0", s_axi.rvalid); else n_pass++;
    n_checks++; if (s_axi.arready !== 1'b1) $display("FAIL midrst_arready: got %b, expected 1", s_axi.arready); else n_pass++;
    push_exp(model_mem[0], 2'b00, 1'b1, 4'd7);
    do_read(4'd7, 32'h0, 8'd0, INCR, 1'b0, "midrst_reread");
  endtask

  task automatic test_errors();
    logic [1:0] br; logic [3:0] bi; int lat;
    for (int i = 0; i < 3; i++) push_exp('0, 2'b10, i == 2, 4'd9);
    do_read(4'd9, 32'h0, 8'd2, WRAP, 1'b0, "wrap_read");
    wq_data.push_back(rand_word()); wq_strb.push_back('1);
    do_write(4'd10, 32'h10000, 8'd0, INCR, 0, br, bi, lat);
    n_checks++; if (br !== 2'b11 || bi !== 4'd10) $display("FAIL decerr_b: got resp %b id %h, expected 11 a", br, bi); else n_pass++;
    wq_data.push_back(rand_word()); wq_strb.push_back('1);
    do_write(4'd11, 32'h80, 8'd0, WRAP, 0, br, bi, lat);
    n_checks++; if (br !== 2'b10) $display("FAIL wrap_bresp: got %b, expected 10", br); else n_pass++;
    push_exp(model_mem[0], 2'b00, 1'b0, 4'd1);
    push_exp(model_mem[1], 2'b00, 1'b0, 4'd1);
    push_exp(model_mem[2], 2'b00, 1'b1, 4'd1);
    do_read(4'd1, 32'h0, 8'd2, INCR, 1'b0, "err_unchanged");
    push_exp('0, 2'b11, 1'b1, 4'd2);
    do_read(4'd2, 32'h10000, 8'd0, INCR, 1'b0, "decerr_read");
    push_exp('0, 2'b11, 1'b1, 4'd3);
    do_read(4'd3, 32'h10040, 8'd0, WRAP, 1'b0, "decerr_over_slverr");
  endtask

  task automatic test_early_wlast();
    logic [1:0] br; logic [3:0] bi; int lat, exp_lat;
`ifdef AXI4_MEM_RESPONDER_BSTALL_EN
    exp_lat = 16;
`else
    exp_lat = 0;
`endif
    for (int i = 0; i < 2; i++) begin wq_data.push_back(rand_word()); wq_strb.push_back('1); end
    for (int i = 0; i < 2; i++) m_write(32'h100 + 32'(i * 64), wq_data[i], '1);
    do_write(4'd12, 32'h100, 8'd3, INCR, 1, br, bi, lat);
    n_checks++; if (br !== 2'b10) $display("FAIL early_bresp: got %b, expected 10", br); else n_pass++;
    n_checks++; if (lat !== exp_lat) $display("FAIL early_blat: got %0d, expected %0d", lat, exp_lat); else n_pass++;
    for (int i = 0; i < 4; i++) push_exp(model_mem[4 + i], 2'b00, i == 3, 4'd13);
    do_read(4'd13, 32'h100, 8'd3, INCR, 1'b0, "early_read");
  endtask

  task automatic test_back_to_back();
    logic [1:0] br; logic [3:0] bi; int lat;
    logic [DW-1:0] d0, d1;
    d0 = rand_word(); d1 = rand_word();
    wq_data.push_back(d0); wq_strb.push_back('1);
    wq_data.push_back(d1); wq_strb.push_back('1);
    for (int i = 0; i < 4; i++) push_exp(model_mem[i], 2'b00, i == 3, 4'd14);
    fork
      do_write(4'd15, 32'h300, 8'd1, INCR, 1, br, bi, lat);
      do_read(4'd14, 32'h0, 8'd3, INCR, 1'b0, "concurrent_read");
    join
    m_write(32'h300, d0, '1);
    m_write(32'h340, d1, '1);
    n_checks++; if (br !== 2'b00 || bi !== 4'd15) $display("FAIL concurrent_b: got resp %b id %h, expected 00 f", br, bi); else n_pass++;
    push_exp(model_mem[widx(32'h300)], 2'b00, 1'b0, 4'd0);
    push_exp(model_mem[widx(32'h340)], 2'b00, 1'b1, 4'd0);
    do_read(4'd0, 32'h300, 8'd1, INCR, 1'b1, "concurrent_readback");
  endtask

  initial begin
    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0;
    s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0;
    s_axi.arburst = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_partial_strobe();
    test_incr_burst();
    test_fixed_burst();
    test_reset_mid_burst();
    test_errors();
    test_early_wlast();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi4_mem_responder.md
Name: axi4_mem_responder

Overview:
- AXI4 slave/responder backed by on-chip dual-port RAM.
- Terminates the m_axi_* master port of the NoC-to-AXI4 bridge on FPGA/sim builds with no DDR controller.
- Independent read and write FSMs; INCR/FIXED bursts, byte strobes, in-order responses per channel.

Parameters:
MEM_DEPTH_LOG2, 10, log2 of RAM depth in `AXI4_DATA_WIDTH-bit words
BASE_ADDR, `AXI4_ADDR_WIDTH'h0, byte address of word 0; window = BASE_ADDR .. BASE_ADDR + (2^MEM_DEPTH_LOG2 * `AXI4_DATA_WIDTH/8) - 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awid/awaddr/awlen/awsize/awburst  in  `AXI4_ID/ADDR/LEN/SIZE/BURST_WIDTH  AW payload
s_axi_awvalid  in  1  / s_axi_awready  out  1  AW handshake
s_axi_wdata/wstrb  in  `AXI4_DATA_WIDTH/`AXI4_STRB_WIDTH  write data, byte enables
s_axi_wlast  in  1  last W beat
s_axi_wvalid  in  1  / s_axi_wready  out  1  W handshake
s_axi_bid/bresp  out  `AXI4_ID_WIDTH/`AXI4_RESP_WIDTH  write response
s_axi_bvalid  out  1  / s_axi_bready  in  1  B handshake
s_axi_arid/araddr/arlen/arsize/arburst  in  widths as AW  AR payload
s_axi_arvalid  in  1  / s_axi_arready  out  1  AR handshake
s_axi_rid/rdata/rresp  out  `AXI4_ID_WIDTH/`AXI4_DATA_WIDTH/`AXI4_RESP_WIDTH  read beat
s_axi_rlast  out  1  last R beat
s_axi_rvalid  out  1  / s_axi_rready  in  1  R handshake
- lock/cache/prot/qos/region/user are not ports; the wrapper leaves them open.

Behaviour:
- Reset: all outputs 0 except awready=arready=1. Both FSMs go to IDLE; in-flight bursts are dropped; RAM contents are retained.
- Word index = (addr - BASE_ADDR) >> log2(`AXI4_DATA_WIDTH/8), truncated to MEM_DEPTH_LOG2 bits.
- Beat address step: INCR += 1<<size; FIXED += 0.
- Error response: WRAP burst (2'b10) or a start address outside the window -> whole burst flagged. Resp SLVERR(2'b10) for WRAP, DECERR(2'b11) for out-of-window. RAM is not written; rdata=0.
- Error priority: DECERR over SLVERR.
- A burst that starts in-window and runs past the end is NOT checked per beat: the index wraps modulo depth and resp is OKAY.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1, wready=0. On AW handshake, latch id/addr/len/size/burst/err -> W_DATA.
  - W_DATA: awready=0, wready=1. Each W handshake writes wdata under wstrb in the same cycle (RAM updated next edge) and advances the address.
  - wlast or beat count == awlen -> W_RESP. Whichever occurs first ends the burst. On mismatch, bresp=SLVERR unless already DECERR.
  - W_RESP: bvalid=1 with latched id/resp until bready, then W_IDLE. awready is low throughout, so there is 0-cycle AW accept turnaround only from W_IDLE.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch -> R_FETCH.
  - R_FETCH: 1-cycle synchronous RAM read -> R_DATA.
  - R_DATA: rvalid=1, rdata/rid/rresp/rlast stable while rready=0. rlast=1 when beat == arlen.
  - On handshake with rlast -> R_IDLE; otherwise advance the address and go to R_FETCH.
  - First-beat latency from AR handshake is 2 cycles; sustained rate is 1 beat per 2 cycles.
- Read-during-write to the same word in the same cycle returns old data (read-first).
- Reads and writes proceed concurrently; there is no ordering between channels.
- arlen up to 255 is supported; the beat counter is 8 bits.

Optional Feature:
- Macro: AXI4_MEM_RESPONDER_BSTALL_EN.
- Defined: W_RESP waits 16 cycles (counter reset on entry) before asserting bvalid. This exercises the bridge's outstanding-write queue.
- Undefined: bvalid asserts on the cycle W_RESP is entered.

Test Plan:
- Reset mid-burst: AR len=3 issued, rst pulsed after beat 1 -> next cycle rvalid=0, arready=1. A fresh AR to the same address returns the preloaded data.
- Single write: awaddr=0x40, len=0, size=6, wstrb=all ones, wdata=0xA5.. -> bvalid with bresp=0, bid echoed. AR to 0x40 returns the same data with rlast=1, rresp=0.
- Partial strobe: write wstrb=0x...0F over known pattern -> readback changes only bytes 0-3.
- INCR burst len=3 at 0x0 with rready toggling every cycle -> 4 beats with ascending words, payload held stable while stalled, rlast on beat 3 only.
- Errors: AR burst=WRAP -> 1..len+1 beats rresp=2'b10, rdata=0. AW at BASE_ADDR+window -> bresp=2'b11, RAM unchanged.
- Early wlast: awlen=3 but wlast on beat 1 -> bresp=2'b10, beats 0-1 written, bvalid 1 cycle later (or 16 cycles with the macro defined).
